// File: rtl/gshare_branch_predictor.sv
// Next-PC predictor: tagged BTB for targets plus a gshare PHT of 2-bit counters.
// Prediction is combinational from read_addr; EX resolution trains the tables and signals flushes.
module gshare_branch_predictor #(
  parameter int         XLEN        = 32,
  parameter int         BTB_ENTRIES = 32,
  parameter int         PHT_ENTRIES = 256,
  parameter int         HIST_BITS   = 8,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [XLEN-1:0]                read_addr,
  output logic [XLEN-1:0]                next_pc,
  output logic [$clog2(PHT_ENTRIES)-1:0] pred_pht_idx,
  input  logic                           upd_valid,
  input  logic [XLEN-1:0]                upd_pc,
  input  logic [XLEN-1:0]                upd_pred_pc,
  input  logic [$clog2(PHT_ENTRIES)-1:0] upd_pht_idx,
  input  logic                           upd_is_branch,
  input  logic                           upd_is_jump,
  input  logic                           upd_taken,
  input  logic [XLEN-1:0]                upd_target,
  output logic                           is_flush,
  output logic [XLEN-1:0]                flush_pc,
  output logic [31:0]                    mispredict_cnt
);

  localparam int BTB_W = $clog2(BTB_ENTRIES);
  localparam int PHT_W = $clog2(PHT_ENTRIES);
  localparam int TAG_W = XLEN - BTB_W - 2;
  localparam int GHR_W = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [BTB_ENTRIES-1:0] r_btb_valid;
  logic [BTB_ENTRIES-1:0] r_btb_jump;
  logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
  logic [1:0]             r_pht        [PHT_ENTRIES];
  logic [GHR_W-1:0]       r_ghr;
  logic [31:0]            r_mispredict_cnt;

  logic [BTB_W-1:0] w_rd_btb_idx;
  logic [PHT_W-1:0] w_rd_pht_idx;
  logic [PHT_W-1:0] w_ghr_ext;
  logic [GHR_W-1:0] w_ghr_next;
  logic             w_hit;
  logic             w_take;
  logic [XLEN-1:0]  w_actual;
  logic             w_flush;
  logic [BTB_W-1:0] w_upd_btb_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic [1:0]       w_ctr;
  logic [1:0]       w_ctr_next;
  logic             w_btb_wr;
  logic             w_btb_inv;

  // With no history the GHR is a dead constant and the PHT degenerates to bimodal.
  generate
    if (HIST_BITS == 0) begin : g_no_hist
      assign w_ghr_ext  = '0;
      assign w_ghr_next = r_ghr;
    end else if (HIST_BITS == 1) begin : g_hist1
      assign w_ghr_ext  = PHT_W'(r_ghr);
      assign w_ghr_next = upd_taken;
    end else begin : g_hist
      assign w_ghr_ext  = PHT_W'(r_ghr);
      assign w_ghr_next = {r_ghr[GHR_W-2:0], upd_taken};
    end
  endgenerate

  assign w_rd_btb_idx = read_addr[BTB_W+1:2];
  assign w_rd_pht_idx = read_addr[PHT_W+1:2] ^ w_ghr_ext;
  assign w_hit        = r_btb_valid[w_rd_btb_idx] &&
                        (r_btb_tag[w_rd_btb_idx] == read_addr[XLEN-1:BTB_W+2]);
  assign w_take       = !reset && w_hit &&
                        (r_btb_jump[w_rd_btb_idx] || r_pht[w_rd_pht_idx][1]);
  assign next_pc      = w_take ? r_btb_target[w_rd_btb_idx] : read_addr + XLEN'(4);
  assign pred_pht_idx = w_rd_pht_idx;

  assign w_actual = upd_taken ? upd_target : upd_pc + XLEN'(4);
  assign w_flush  = upd_valid && !reset && (w_actual != upd_pred_pc);
  assign is_flush = w_flush;
  assign flush_pc = w_actual;
  assign mispredict_cnt = r_mispredict_cnt;

  assign w_upd_btb_idx = upd_pc[BTB_W+1:2];
  assign w_upd_tag     = upd_pc[XLEN-1:BTB_W+2];
  assign w_ctr         = r_pht[upd_pht_idx];
  assign w_ctr_next    = upd_taken ? ((w_ctr == 2'd3) ? 2'd3 : w_ctr + 2'd1)
                                   : ((w_ctr == 2'd0) ? 2'd0 : w_ctr - 2'd1);
  assign w_btb_wr      = upd_valid && (upd_is_branch || upd_is_jump) && upd_taken;
  // A non-control instruction that was predicted taken hit a stale or aliased entry.
  assign w_btb_inv     = upd_valid && !upd_is_branch && !upd_is_jump && w_flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btb_valid      <= '0;
      r_ghr            <= '0;
      r_mispredict_cnt <= '0;
      for (int i = 0; i < PHT_ENTRIES; i++) r_pht[i] <= CTR_INIT;
    end else begin
      if (upd_valid && upd_is_branch) begin
        r_pht[upd_pht_idx] <= w_ctr_next;
        r_ghr              <= w_ghr_next;
      end
      if (w_btb_wr)       r_btb_valid[w_upd_btb_idx] <= 1'b1;
      else if (w_btb_inv) r_btb_valid[w_upd_btb_idx] <= 1'b0;
      if (w_flush) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  // Payload fields are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_btb_wr) begin
      r_btb_tag[w_upd_btb_idx]    <= w_upd_tag;
      r_btb_target[w_upd_btb_idx] <= upd_target;
      r_btb_jump[w_upd_btb_idx]   <= upd_is_jump;
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Bench for gshare_branch_predictor (HIST_BITS=2): directed scenarios plus random
// fetch/resolve pairs, checked against a behavioural model through an expected queue.
module tb_gshare_branch_predictor;

  localparam int XLEN = 32;
  localparam int HB   = 2;
  localparam int EW   = 105;

  logic            clk;
  logic            reset;
  logic [XLEN-1:0] read_addr;
  logic [XLEN-1:0] next_pc;
  logic [7:0]      pred_pht_idx;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_pred_pc;
  logic [7:0]      upd_pht_idx;
  logic            upd_is_branch;
  logic            upd_is_jump;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            is_flush;
  logic [XLEN-1:0] flush_pc;
  logic [31:0]     mispredict_cnt;

  gshare_branch_predictor #(
    .XLEN(XLEN), .BTB_ENTRIES(32), .PHT_ENTRIES(256), .HIST_BITS(HB), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .reset(reset), .read_addr(read_addr), .next_pc(next_pc),
    .pred_pht_idx(pred_pht_idx), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_pred_pc(upd_pred_pc), .upd_pht_idx(upd_pht_idx), .upd_is_branch(upd_is_branch),
    .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
    .is_flush(is_flush), .flush_pc(flush_pc), .mispredict_cnt(mispredict_cnt)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic        m_valid [32];
  logic [24:0] m_tag   [32];
  logic [31:0] m_tgt   [32];
  logic        m_jmp   [32];
  logic [1:0]  m_pht   [256];
  logic [1:0]  m_ghr;
  logic [31:0] m_cnt;
  logic [31:0] m_last_npc;
  logic [7:0]  m_last_idx;
  logic        m_flush;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    for (int i = 0; i < 256; i++) m_pht[i] = 2'b01;
    m_ghr = '0;
    m_cnt = '0;
  endtask

  // Called at negedge with inputs settled: push expectation, then compare before posedge.
  task automatic eval();
    logic [31:0] e_npc, actual;
    logic [7:0]  e_idx;
    logic        take;
    logic [EW-1:0] e;
    int bi;
    if (reset) model_reset();
    bi     = int'(read_addr[6:2]);
    e_idx  = read_addr[9:2] ^ {6'b0, m_ghr};
    take   = m_valid[bi] && (m_tag[bi] == read_addr[31:7]) && (m_jmp[bi] || m_pht[e_idx][1]);
    e_npc  = take ? m_tgt[bi] : read_addr + 32'd4;
    actual = upd_taken ? upd_target : upd_pc + 32'd4;
    m_flush = upd_valid && !reset && (actual != upd_pred_pc);
    m_last_npc = e_npc;
    m_last_idx = e_idx;
    exp_q.push_back({e_npc, e_idx, m_flush, actual, m_cnt});
    #3;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty t=%0t", $time);
    end else begin
      e = exp_q.pop_front();
      check_eq("next_pc", next_pc, e[104:73]);
      check_eq("pht_idx", {24'b0, pred_pht_idx}, {24'b0, e[72:65]});
      check_eq("is_flush", {31'b0, is_flush}, {31'b0, e[64]});
      check_eq("flush_pc", flush_pc, e[63:32]);
      check_eq("mp_cnt", mispredict_cnt, e[31:0]);
    end
  endtask

  task automatic adv();
    int bi;
    logic [1:0] c;
    @(posedge clk);
    if (!reset && upd_valid) begin
      bi = int'(upd_pc[6:2]);
      if (upd_is_branch) begin
        c = m_pht[upd_pht_idx];
        if (upd_taken && c != 2'd3) c = c + 2'd1;
        else if (!upd_taken && c != 2'd0) c = c - 2'd1;
        m_pht[upd_pht_idx] = c;
        m_ghr = {m_ghr[0], upd_taken};
      end
      if ((upd_is_branch || upd_is_jump) && upd_taken) begin
        m_valid[bi] = 1'b1;
        m_tag[bi]   = upd_pc[31:7];
        m_tgt[bi]   = upd_target;
        m_jmp[bi]   = upd_is_jump;
      end else if (!upd_is_branch && !upd_is_jump && m_flush) begin
        m_valid[bi] = 1'b0;
      end
      if (m_flush) m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  // driver: fetch pc (junk on the idle update bus), then resolve it next cycle
  task automatic run_inst(input logic [31:0] pc, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt);
    logic [31:0] p_pc;
    logic [7:0]  p_idx;
    read_addr     = pc;
    upd_valid     = 1'b0;
    upd_pc        = $urandom & 32'hFFFF_FFFC;
    upd_pred_pc   = $urandom;
    upd_target    = $urandom;
    upd_taken     = 1'($urandom_range(0, 1));
    upd_is_branch = 1'($urandom_range(0, 1));
    upd_is_jump   = 1'($urandom_range(0, 1));
    upd_pht_idx   = 8'($urandom_range(0, 255));
    eval();
    adv();
    p_pc  = m_last_npc;
    p_idx = m_last_idx;
    read_addr     = 32'($urandom_range(0, 1023)) << 2;
    upd_valid     = 1'b1;
    upd_pc        = pc;
    upd_pred_pc   = p_pc;
    upd_pht_idx   = p_idx;
    upd_is_branch = br;
    upd_is_jump   = jmp;
    upd_taken     = tk;
    upd_target    = tgt;
    eval();
    adv();
    upd_valid = 1'b0;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic [31:0] pp,
                         input logic br, input logic jmp, input logic tk, input logic [31:0] tgt);
    upd_valid = v; upd_pc = pc; upd_pred_pc = pp; upd_pht_idx = 8'h00;
    upd_is_branch = br; upd_is_jump = jmp; upd_taken = tk; upd_target = tgt;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    eval();
    adv();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h80; pcs[1] = 32'h100; pcs[2] = 32'h180; pcs[3] = 32'h1080;
    reset = 1'b1;
    read_addr = 32'h0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // after reset: plain fall-through
    read_addr = 32'h40;
    eval();
    check_eq("t1_npc", next_pc, 32'h44);
    check_eq("t1_idx", {24'b0, pred_pht_idx}, 32'h10);
    check_eq("t1_cnt", mispredict_cnt, 32'h0);
    adv();

    // jal 0x100 -> 0x200, first resolve mispredicts, then learned
    set_upd(1'b1, 32'h100, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200);
    eval();
    check_eq("t2_flush", {31'b0, is_flush}, 32'h1);
    check_eq("t2_fpc", flush_pc, 32'h200);
    adv();
    read_addr = 32'h100;
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b1, 32'h200);
    eval();
    check_eq("t2_npc", next_pc, 32'h200);
    check_eq("t2_noflush", {31'b0, is_flush}, 32'h0);
    adv();

    // non-control instruction hitting the jal entry
    set_upd(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000);
    eval();
    check_eq("t5_flush", {31'b0, is_flush}, 32'h1);
    check_eq("t5_fpc", flush_pc, 32'h104);
    adv();
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    eval();
    check_eq("t5_npc", next_pc, 32'h104);
    adv();

    // branch trained taken then one not-taken
    for (int i = 0; i < 3; i++) run_inst(32'h80, 1'b1, 1'b0, 1'b1, 32'h300);
    run_inst(32'h80, 1'b1, 1'b0, 1'b0, 32'h300);

    // alternating branch: gshare learns the pattern after two mispredicts
    pulse_reset();
    for (int i = 0; i < 8; i++) run_inst(32'h80, 1'b1, 1'b0, (i % 2) == 0, 32'h300);
    read_addr = 32'h40;
    eval();
    check_eq("t4_cnt", mispredict_cnt, 32'h2);
    adv();

    // reset during an update discards it and clears the BTB
    run_inst(32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
    reset = 1'b1;
    read_addr = 32'h100;
    set_upd(1'b1, 32'h100, 32'h104, 1'b0, 1'b1, 1'b1, 32'h200);
    eval();
    check_eq("t6_npc", next_pc, 32'h104);
    check_eq("t6_flush", {31'b0, is_flush}, 32'h0);
    check_eq("t6_cnt", mispredict_cnt, 32'h0);
    adv();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    eval();
    check_eq("t6_gone", next_pc, 32'h104);
    adv();

    // random mix of branches, jumps and plain instructions over aliasing PCs
    for (int i = 0; i < 80; i++) begin
      int k;
      logic br, jmp, tk;
      k   = $urandom_range(0, 2);
      br  = (k == 0);
      jmp = (k == 1);
      tk  = jmp ? 1'b1 : (br ? 1'($urandom_range(0, 1)) : 1'b0);
      run_inst(pcs[$urandom_range(0, 3)], br, jmp, tk,
               32'($urandom_range(0, 4095)) << 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
